// File: rtl/rcal_activation_if.sv
// Signal bundle between rcal_activation, the multiply-accumulate producer and the memory system.
interface rcal_activation_if #(
  parameter int unsigned ADDR_W = 17
);
  logic              start_rcal;
  logic [31:0]       W_in;
  logic [31:0]       F_in;
  logic [ADDR_W-1:0] outputloc_in;
  logic [4:0]        postshift_in;
  logic              done_layer_in;
  logic              grant;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [31:0]       rd_data;
  logic              rd_valid;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              wr_ack;
  logic              done_layer_out;
  logic              overflow;

  modport master (
    output start_rcal, W_in, F_in, outputloc_in, postshift_in, done_layer_in,
    output rd_data, rd_valid, wr_ack,
    input  grant, rd_req, rd_addr, wr_req, wr_addr, wr_data, done_layer_out, overflow
  );

  modport slave (
    input  start_rcal, W_in, F_in, outputloc_in, postshift_in, done_layer_in,
    input  rd_data, rd_valid, wr_ack,
    output grant, rd_req, rd_addr, wr_req, wr_addr, wr_data, done_layer_out, overflow
  );
endinterface

// File: rtl/rcal_activation.sv
// Buffers neuron results in a FIFO, evaluates the quadratic activation polynomial
// by Horner's method from fetched coefficients, and writes the saturated result.
module rcal_activation #(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned GRANT_SLACK = 5,
  parameter int unsigned ADDR_W      = 17
) (
  input logic             clk,
  input logic             reset,
  rcal_activation_if.slave bus
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned FRAC_W = 24;
  localparam int unsigned COEF_W = 32;
  localparam int unsigned MUL1_W = COEF_W + FRAC_W + 1;
  localparam int unsigned ACC_W  = MUL1_W + 1;
  localparam int unsigned MUL2_W = ACC_W + FRAC_W + 1;
  localparam int unsigned Y_W    = ACC_W + 1;

  localparam logic signed [Y_W-1:0] SAT_MAX = Y_W'(64'sh7FFF_FFFE);
  localparam logic signed [Y_W-1:0] SAT_MIN = -SAT_MAX;

  typedef struct packed {
    logic [ADDR_W-1:0] w;
    logic [FRAC_W-1:0] f;
    logic [ADDR_W-1:0] oloc;
    logic [4:0]        pshift;
    logic              done;
    logic              compute;
  } entry_t;

  typedef enum logic [3:0] {IDLE, RD_A, RD_B, RD_C, MUL1, MUL2, ADD, WRITE, FLAG} state_t;

  state_t state_q, state_d;
  entry_t fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  entry_t cur_q, cur_d, head, new_entry;
  logic signed [COEF_W-1:0] c2_q, c1_q, c0_q, c2_d, c1_d, c0_d;
  logic signed [ACC_W-1:0]  h1_q, h1_d, p_q, p_d;
  logic signed [FRAC_W:0]   f_ext;
  logic signed [MUL1_W-1:0] mul1;
  logic signed [MUL2_W-1:0] mul2;
  logic signed [Y_W-1:0]    y, s;

  logic              grant_q, rd_req_q, rd_req_d, wr_req_q, wr_req_d, done_q, done_d, overflow_q;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic              push, pop, full, push_ok;
  logic              unused_bits;

  assign unused_bits = ^{bus.W_in[31:ADDR_W], bus.F_in[31:FRAC_W]};

  // Entry capture and FIFO occupancy
  always_comb begin
    new_entry         = '0;
    new_entry.w       = bus.W_in[ADDR_W-1:0];
    new_entry.f       = bus.F_in[FRAC_W-1:0];
    new_entry.oloc    = bus.outputloc_in;
    new_entry.pshift  = bus.postshift_in;
    new_entry.done    = bus.done_layer_in;
    new_entry.compute = bus.start_rcal;
  end

  assign head    = fifo_mem[rd_ptr_q];
  assign push    = bus.start_rcal | bus.done_layer_in;
  assign full    = (count_q == CNT_W'(FIFO_DEPTH));
  assign push_ok = push & (~full | pop);
  assign f_ext   = {1'b0, cur_q.f};

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr_q] <= new_entry;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      grant_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q    <= count_q + CNT_W'(push_ok) - CNT_W'(pop);
      grant_q    <= (CNT_W'(FIFO_DEPTH) - count_q) >= CNT_W'(GRANT_SLACK);
      overflow_q <= overflow_q | (push & full & ~pop);
    end
  end

  // FSM state and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cur_q     <= '0;
      c2_q      <= '0;
      c1_q      <= '0;
      c0_q      <= '0;
      h1_q      <= '0;
      p_q       <= '0;
      rd_req_q  <= 1'b0;
      rd_addr_q <= '0;
      wr_req_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      c2_q      <= c2_d;
      c1_q      <= c1_d;
      c0_q      <= c0_d;
      h1_q      <= h1_d;
      p_q       <= p_d;
      rd_req_q  <= rd_req_d;
      rd_addr_q <= rd_addr_d;
      wr_req_q  <= wr_req_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
    end
  end

  // Next state, Horner evaluation and registered-output next values
  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    cur_d     = cur_q;
    c2_d      = c2_q;
    c1_d      = c1_q;
    c0_d      = c0_q;
    h1_d      = h1_q;
    p_d       = p_q;
    rd_req_d  = rd_req_q;
    rd_addr_d = rd_addr_q;
    wr_req_d  = wr_req_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    mul1      = '0;
    mul2      = '0;
    y         = '0;
    s         = '0;
    unique case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop   = 1'b1;
          cur_d = head;
          if (head.compute) begin
            state_d   = RD_A;
            rd_req_d  = 1'b1;
            rd_addr_d = head.w;
          end else begin
            state_d = FLAG;
            done_d  = 1'b1;
          end
        end
      end
      RD_A: begin
        if (bus.rd_valid) begin
          c2_d      = bus.rd_data;
          rd_addr_d = cur_q.w + ADDR_W'(1);
          state_d   = RD_B;
        end
      end
      RD_B: begin
        if (bus.rd_valid) begin
          c1_d      = bus.rd_data;
          rd_addr_d = cur_q.w + ADDR_W'(2);
          state_d   = RD_C;
        end
      end
      RD_C: begin
        if (bus.rd_valid) begin
          c0_d     = bus.rd_data;
          rd_req_d = 1'b0;
          state_d  = MUL1;
        end
      end
      MUL1: begin
        mul1    = MUL1_W'(c2_q) * MUL1_W'(f_ext);
        h1_d    = ACC_W'(mul1 >>> FRAC_W) + ACC_W'(c1_q);
        state_d = MUL2;
      end
      MUL2: begin
        mul2    = MUL2_W'(h1_q) * MUL2_W'(f_ext);
        p_d     = ACC_W'(mul2 >>> FRAC_W);
        state_d = ADD;
      end
      ADD: begin
        y = Y_W'(p_q) + Y_W'(c0_q);
        s = y >>> cur_q.pshift;
        if (s > SAT_MAX)      wr_data_d = 32'h7FFF_FFFE;
        else if (s < SAT_MIN) wr_data_d = 32'h8000_0002;
        else                  wr_data_d = 32'(s);
        wr_req_d  = 1'b1;
        wr_addr_d = cur_q.oloc;
        state_d   = WRITE;
      end
      WRITE: begin
        if (bus.wr_ack) begin
          wr_req_d = 1'b0;
          done_d   = cur_q.done;
          state_d  = IDLE;
        end
      end
      FLAG:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.grant          = grant_q;
  assign bus.rd_req         = rd_req_q;
  assign bus.rd_addr        = rd_addr_q;
  assign bus.wr_req         = wr_req_q;
  assign bus.wr_addr        = wr_addr_q;
  assign bus.wr_data        = wr_data_q;
  assign bus.done_layer_out = done_q;
  assign bus.overflow       = overflow_q;

endmodule

// File: tb/tb_rcal_activation.sv
// Directed-vector bench for rcal_activation with a zero-wait coefficient memory model.
`timescale 1ns/1ps
module tb_rcal_activation;
  localparam int unsigned ADDR_W = 17;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rcal_activation_if #(.ADDR_W(ADDR_W)) bus();

  rcal_activation #(.FIFO_DEPTH(8), .GRANT_SLACK(5), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] cmem [0:1023];
  logic rd_en, ack_en;
  assign bus.rd_valid = bus.rd_req & rd_en;
  assign bus.rd_data  = cmem[bus.rd_addr[9:0]];
  assign bus.wr_ack   = bus.wr_req & ack_en;

  logic [48:0] wq[$];
  int rd_cycles = 0;
  int dlo_cnt   = 0;
  always @(negedge clk) begin
    if (bus.wr_req && bus.wr_ack) wq.push_back({bus.wr_addr, bus.wr_data});
    if (bus.rd_req) rd_cycles++;
    if (bus.done_layer_out) dlo_cnt++;
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic [16:0] w;
    logic [23:0] f;
    logic [31:0] c2, c1, c0;
    logic [16:0] oloc;
    logic [4:0]  ps;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [8];

  task automatic load_coefs(input logic [16:0] w, input logic [31:0] c2, input logic [31:0] c1,
                            input logic [31:0] c0);
    logic [16:0] a;
    a = w;          cmem[a[9:0]] = c2;
    a = w + 17'd1;  cmem[a[9:0]] = c1;
    a = w + 17'd2;  cmem[a[9:0]] = c0;
  endtask

  // Entered and left at #1 after a rising edge.
  task automatic run_vec(input vec_t v, input string tag);
    int n;
    int base;
    logic [48:0] rec;
    load_coefs(v.w, v.c2, v.c1, v.c0);
    base = wq.size();
    bus.start_rcal   = 1'b1;
    bus.W_in         = {15'd0, v.w};
    bus.F_in         = {8'd0, v.f};
    bus.outputloc_in = v.oloc;
    bus.postshift_in = v.ps;
    @(posedge clk); #1;
    bus.start_rcal = 1'b0;
    n = 0;
    while (!bus.wr_req && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, " wr_req latency"}, 64'(n), 64'd7);
    repeat (3) @(posedge clk);
    #1;
    check({tag, " write count"}, 64'(wq.size() - base), 64'd1);
    if (wq.size() > base) begin
      rec = wq[base];
      check({tag, " wr_addr"}, 64'(rec[48:32]), 64'(v.oloc));
      check({tag, " wr_data"}, 64'(rec[31:0]), 64'(v.exp));
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, base, rbase, dbase;
    logic [16:0] a;
    logic [48:0] rec;

    vecs[0] = '{17'h00100, 24'h000000, 32'h01000000, 32'h00000000, 32'h00800000, 17'h02000, 5'd0,  32'h00800000};
    vecs[1] = '{17'h00104, 24'h800000, 32'h01000000, 32'h01000000, 32'h00000000, 17'h02001, 5'd1,  32'h00600000};
    vecs[2] = '{17'h00108, 24'hFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 17'h02002, 5'd0,  32'h7FFFFFFE};
    vecs[3] = '{17'h0010C, 24'hFFFFFF, 32'h80000000, 32'h80000000, 32'h80000000, 17'h02003, 5'd0,  32'h80000002};
    vecs[4] = '{17'h00110, 24'h400000, 32'h00000000, 32'hFF000000, 32'h00000000, 17'h02004, 5'd0,  32'hFFC00000};
    vecs[5] = '{17'h1FFFF, 24'h400000, 32'h02000000, 32'h00000000, 32'h00100000, 17'h1FFFF, 5'd2,  32'h000C0000};
    vecs[6] = '{17'h00120, 24'h000000, 32'h00000000, 32'h00000000, 32'hFF000000, 17'h02006, 5'd31, 32'hFFFFFFFF};
    vecs[7] = '{17'h00130, 24'h000001, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 17'h02007, 5'd0,  32'hFFFFFFFF};

    reset = 1'b1;
    bus.start_rcal = 1'b0; bus.W_in = '0; bus.F_in = '0; bus.outputloc_in = '0;
    bus.postshift_in = '0; bus.done_layer_in = 1'b0;
    rd_en = 1'b1; ack_en = 1'b1;
    for (int i = 0; i < 1024; i++) cmem[i] = '0;

    repeat (3) @(posedge clk);
    #1;
    check("reset grant", 64'(bus.grant), 64'd1);
    check("reset rd_req", 64'(bus.rd_req), 64'd0);
    check("reset wr_req", 64'(bus.wr_req), 64'd0);
    check("reset wr_data", 64'(bus.wr_data), 64'd0);
    check("reset done_layer_out", 64'(bus.done_layer_out), 64'd0);
    check("reset overflow", 64'(bus.overflow), 64'd0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Eight back-to-back results with reads stalled; the last one closes the layer
    rd_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      a = 17'h200 + 17'(4 * i);
      load_coefs(a, 32'h0, 32'h01000000, 32'(i + 1) << 20);
      bus.start_rcal    = 1'b1;
      bus.W_in          = {15'd0, a};
      bus.F_in          = 32'(i) << 20;
      bus.outputloc_in  = 17'h3000 + 17'(i);
      bus.postshift_in  = 5'd0;
      bus.done_layer_in = (i == 7);
      @(posedge clk); #1;
      check($sformatf("burst grant %0d", i), 64'(bus.grant), (i < 5) ? 64'd1 : 64'd0);
    end
    bus.start_rcal = 1'b0; bus.done_layer_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("burst grant held low", 64'(bus.grant), 64'd0);
    check("burst no overflow", 64'(bus.overflow), 64'd0);
    base  = wq.size();
    dbase = dlo_cnt;
    rd_en = 1'b1;
    n = 0;
    while ((wq.size() - base) < 8 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("burst write count", 64'(wq.size() - base), 64'd8);
    check("done after last ack", 64'(bus.done_layer_out), 64'd1);
    @(posedge clk); #1;
    check("done pulse width", 64'(bus.done_layer_out), 64'd0);
    check("burst done pulses", 64'(dlo_cnt - dbase), 64'd1);
    for (int i = 0; i < 8; i++) begin
      if (wq.size() > base + i) begin
        rec = wq[base + i];
        check($sformatf("burst %0d addr", i), 64'(rec[48:32]), 64'(17'h3000 + 17'(i)));
        check($sformatf("burst %0d data", i), 64'(rec[31:0]), 64'((2 * i + 1) << 20));
      end
    end
    check("grant after drain", 64'(bus.grant), 64'd1);

    // Lone end-of-layer marker
    rbase = rd_cycles; base = wq.size(); dbase = dlo_cnt;
    bus.done_layer_in = 1'b1;
    @(posedge clk); #1;
    bus.done_layer_in = 1'b0;
    n = 0;
    while (!bus.done_layer_out && n < 5) begin
      @(posedge clk); #1;
      n++;
    end
    check("lone done latency", 64'(n >= 1 && n <= 2), 64'd1);
    @(posedge clk); #1;
    check("lone done width", 64'(bus.done_layer_out), 64'd0);
    repeat (4) @(posedge clk);
    #1;
    check("lone done no reads", 64'(rd_cycles - rbase), 64'd0);
    check("lone done no writes", 64'(wq.size() - base), 64'd0);
    check("lone done pulses", 64'(dlo_cnt - dbase), 64'd1);

    // Reset during a stalled RD_B with a full FIFO
    load_coefs(vecs[0].w, vecs[0].c2, vecs[0].c1, vecs[0].c0);
    bus.start_rcal = 1'b1; bus.W_in = {15'd0, vecs[0].w}; bus.F_in = '0;
    bus.outputloc_in = vecs[0].oloc; bus.postshift_in = 5'd0;
    @(posedge clk); #1;
    bus.start_rcal = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rd_en = 1'b0;
    check("stall rd_req", 64'(bus.rd_req), 64'd1);
    check("stall rd_addr W+1", 64'(bus.rd_addr), 64'h101);
    for (int i = 0; i < 9; i++) begin
      bus.start_rcal = 1'b1;
      @(posedge clk); #1;
    end
    bus.start_rcal = 1'b0;
    check("overflow set", 64'(bus.overflow), 64'd1);
    check("full grant low", 64'(bus.grant), 64'd0);
    @(posedge clk); #1;
    check("overflow sticky", 64'(bus.overflow), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("async rd_req drop", 64'(bus.rd_req), 64'd0);
    check("async wr_req drop", 64'(bus.wr_req), 64'd0);
    check("async done drop", 64'(bus.done_layer_out), 64'd0);
    check("async grant rise", 64'(bus.grant), 64'd1);
    check("async overflow clear", 64'(bus.overflow), 64'd0);
    @(posedge clk);
    @(negedge clk) reset = 1'b0;
    rd_en = 1'b1;
    rbase = rd_cycles; base = wq.size();
    repeat (10) @(posedge clk);
    #1;
    check("fifo emptied no reads", 64'(rd_cycles - rbase), 64'd0);
    check("fifo emptied no writes", 64'(wq.size() - base), 64'd0);
    run_vec(vecs[0], "post-reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/rcal_activation.md
Name: rcal_activation

Overview:
- Consumer end of the multiply-accumulate → rcal interface. Accepts pipelined neuron results (W = coefficient-table address, F = Q0.24 fraction), fetches three activation-polynomial coefficients from coefficient memory, and evaluates the quadratic by Horner's method.
- Applies the per-layer post-shift, saturates, and writes the result to the neuron output location.
- Drives `grant` back to the multiply-accumulator so its in-flight results never overflow the input FIFO.

Parameters:
- FIFO_DEPTH, 8, input FIFO entries (power of 2, ≥ GRANT_SLACK+1).
- GRANT_SLACK, 5, free entries required to hold grant high; covers the upstream in-flight stages.
- ADDR_W, 17, memory address width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start_rcal  in  1  valid strobe for W_in/F_in/outputloc_in/postshift_in in this cycle.
- W_in  in  32  coefficient base address; bits [ADDR_W-1:0] used.
- F_in  in  32  fraction; bits [23:0] used, unsigned Q0.24.
- outputloc_in  in  ADDR_W  result write address.
- postshift_in  in  5  arithmetic right shift applied to the result.
- done_layer_in  in  1  end-of-layer flag.
- grant  out  1  upstream may advance.
- rd_req  out  1  coefficient read request.
- rd_addr  out  ADDR_W  read address.
- rd_data  in  32  signed Q8.24 coefficient.
- rd_valid  in  1  rd_data valid; completes the read.
- wr_req  out  1  result write request.
- wr_addr  out  ADDR_W  write address.
- wr_data  out  32  signed result.
- wr_ack  in  1  completes the write.
- done_layer_out  out  1  one-cycle end-of-layer pulse.
- overflow  out  1  sticky flag: push attempted while FIFO full.

Behaviour:

Reset
- All outputs 0 except grant = 1.
- FIFO empty, FSM in IDLE, all coefficient and intermediate registers 0.
- Reset mid-transaction aborts it immediately; rd_req and wr_req fall asynchronously.

Push
- A push occurs on any edge where start_rcal=1 or done_layer_in=1.
- Entry contents: {W[ADDR_W-1:0], F[23:0], outputloc, postshift, done_layer, compute = start_rcal}.
- done_layer_in=1 with start_rcal=0 pushes a marker entry (compute=0).

Grant and overflow
- grant = (FIFO_DEPTH - count) ≥ GRANT_SLACK, derived from registered count.
- Push while full: entry is dropped, overflow is set, and overflow stays set until reset.
- Simultaneous push and pop on a full FIFO is legal and not an overflow.

FSM
- States: IDLE, RD_A, RD_B, RD_C, MUL1, MUL2, ADD, WRITE, FLAG.
- IDLE: if FIFO non-empty, pop the head and latch it. Go to RD_A if compute=1, else FLAG.
- RD_A/RD_B/RD_C: rd_req=1 with rd_addr = W, W+1, W+2 (modulo 2^ADDR_W) respectively.
  - rd_req and rd_addr are held stable until the cycle rd_valid=1.
  - rd_data is latched as c2, c1, c0; advance on that edge.
  - rd_valid while rd_req=0 is ignored.
- MUL1: h = (c2 × {0,F}) >>> 24, in 57-bit signed; h1 = h + c1 (58-bit).
- MUL2: p = (h1 × {0,F}) >>> 24 (58-bit).
- ADD: y = p + c0; s = y >>> postshift (arithmetic); saturate s to [-0x7FFFFFFE, +0x7FFFFFFE]; register as wr_data.
- WRITE: wr_req=1 with wr_addr = outputloc and wr_data, held stable until wr_ack=1.
  - On the wr_ack edge: go to IDLE; if done_layer=1, pulse done_layer_out in the next cycle.
- FLAG: no memory access; done_layer_out=1 for exactly one cycle, then IDLE.
- Entries complete strictly in FIFO order; only one entry is in the FSM at a time.

Timing
- With zero-wait memory (rd_valid and wr_ack high in the first request cycle), wr_req rises 7 edges after the edge that sampled start_rcal. Sustained throughput is then one result per 8 cycles.

Test Plan:
1. mem[0x100..0x102] = {0x01000000, 0, 0x00800000}; W=0x100, F=0, oloc=0x2000, postshift=0 → one write of 0x00800000 to 0x2000; wr_req rises 7 edges after the push edge.
2. Coefficients {0x01000000, 0x01000000, 0}, F=0x800000, postshift=1 → y=0x00C00000, wr_data=0x00600000.
3. Coefficients {0x7FFFFFFF, 0x7FFFFFFF, 0x7FFFFFFF}, F=0xFFFFFF → wr_data=0x7FFFFFFE; all coefficients 0x80000000 → wr_data=0x80000002.
4. 8 back-to-back start_rcal with rd_valid held low:
   - grant falls in the cycle after count reaches 4 and stays low while free < 5; overflow stays 0.
   - Once rd_valid is released, all 8 writes occur in push order.
5. Last start_rcal carries done_layer_in=1 → done_layer_out pulses one cycle after that write's wr_ack. A lone done_layer_in pulse → done_layer_out within 2 cycles, with no rd_req or wr_req.
6. Assert reset while in RD_B with rd_req=1:
   - rd_req, wr_req and done_layer_out go to 0 and grant goes to 1 immediately, and the FIFO empties.
   - After reset release, a fresh scenario 1 passes.
